// File: rtl/pipe_stall_ctrl_if.sv
// Multi-cycle EX operation handshake between the EX unit
// and the pipeline stall controller.
interface pipe_stall_ctrl_if #(
    parameter int LEN_W = 6
);
    logic             mc_req_i;
    logic [LEN_W-1:0] mc_len_i;
    logic             mc_cancel_i;
    logic             mc_busy_o;
    logic             mc_done_o;

    modport master (
        output mc_req_i,
        output mc_len_i,
        output mc_cancel_i,
        input  mc_busy_o,
        input  mc_done_o
    );

    modport slave (
        input  mc_req_i,
        input  mc_len_i,
        input  mc_cancel_i,
        output mc_busy_o,
        output mc_done_o
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges ID load-use stalls with
// multi-cycle EX ops and counts frozen cycles.
module pipe_stall_ctrl #(
    parameter int LEN_W  = 6,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id_i,
    input  logic              perf_clr_i,
    pipe_stall_ctrl_if.slave  mc,
    output logic [5:0]        stall_o,
    output logic [PERF_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    localparam logic [LEN_W-1:0]  LEN_ZERO = '0;
    localparam logic [LEN_W-1:0]  LEN_ONE  =
        {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0] PERF_ONE =
        {{(PERF_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, done_q;
    logic [PERF_W-1:0]  perf_q, perf_d;
    logic               ex_stall;
    logic               id_stall;

    // FSM and length counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    // Next state, counter update and EX stall request
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ex_stall = 1'b0;
        id_stall = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                id_stall = stallreq_id_i;
                if (mc.mc_cancel_i) begin
                    cnt_d = '0;
                end else if (mc.mc_req_i &&
                             mc.mc_len_i != LEN_ZERO) begin
                    ex_stall = 1'b1;
                    if (mc.mc_len_i == LEN_ONE) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = mc.mc_len_i - LEN_ONE;
                    end
                end
            end
            S_RUN: begin
                ex_stall = 1'b1;
                if (mc.mc_cancel_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - LEN_ONE;
                    if (cnt_q == LEN_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // EX result lands in ex_mem this cycle
                id_stall = stallreq_id_i;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Stall vector: EX wins over ID, forced clear in reset
    always_comb begin
        stall_o = STALL_NONE;
        if (!rst) begin
            stall_o = STALL_NONE;
        end else if (ex_stall) begin
            stall_o = STALL_EX;
        end else if (id_stall) begin
            stall_o = STALL_ID;
        end
    end

    // Saturating frozen-cycle count with clear priority
    always_comb begin
        perf_d = perf_q;
        if (perf_clr_i) begin
            perf_d = '0;
        end else if (stall_o[0] && perf_q != '1) begin
            perf_d = perf_q + PERF_ONE;
        end
    end

    // Performance counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign mc.mc_busy_o = busy_q;
    assign mc.mc_done_o = done_q;
    assign stall_cnt_o  = perf_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed scoreboard bench for pipe_stall_ctrl.
// Expected per-cycle outputs are queued and compared.
module tb_pipe_stall_ctrl;

    typedef struct {
        string       tag;
        logic [5:0]  stall;
        logic        busy;
        logic        done;
        logic [15:0] perf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id  = 1'b0;
    logic        clr = 1'b0;
    logic [5:0]  stall;
    logic [15:0] perf;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_perf = 16'h0000;
    exp_t        sb[$];

    pipe_stall_ctrl_if #(.LEN_W(6)) mc ();

    pipe_stall_ctrl #(.LEN_W(6), .PERF_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_id_i (id),
        .perf_clr_i    (clr),
        .mc            (mc),
        .stall_o       (stall),
        .stall_cnt_o   (perf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, queue expectation, compare, advance
    task automatic step(input string tag,
                        input logic i_id,
                        input logic i_req,
                        input logic [5:0] i_len,
                        input logic i_can,
                        input logic i_clr,
                        input logic [5:0] es,
                        input logic eb,
                        input logic ed);
        exp_t e;
        exp_t g;
        id             = i_id;
        mc.mc_req_i    = i_req;
        mc.mc_len_i    = i_len;
        mc.mc_cancel_i = i_can;
        clr            = i_clr;
        e.tag   = tag;
        e.stall = es;
        e.busy  = eb;
        e.done  = ed;
        e.perf  = exp_perf;
        sb.push_back(e);
        #2;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            chk({g.tag, "_stall"}, 32'(stall), 32'(g.stall));
            chk({g.tag, "_busy"}, 32'(mc.mc_busy_o), 32'(g.busy));
            chk({g.tag, "_done"}, 32'(mc.mc_done_o), 32'(g.done));
            chk({g.tag, "_perf"}, 32'(perf), 32'(g.perf));
        end
        @(posedge clk);
        if (i_clr) exp_perf = 16'h0000;
        else if (es[0] && exp_perf != 16'hFFFF)
            exp_perf = exp_perf + 16'h0001;
        #1;
    endtask

    initial begin
        mc.mc_req_i    = 1'b0;
        mc.mc_len_i    = 6'd0;
        mc.mc_cancel_i = 1'b0;
        id  = 1'b1;
        rst = 1'b0;
        #2;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_busy", 32'(mc.mc_busy_o), 32'h0);
        chk("rst_done", 32'(mc.mc_done_o), 32'h0);
        chk("rst_perf", 32'(perf), 32'h0);
        id = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // ID load-use stall for 3 cycles
        for (int i = 0; i < 3; i++)
            step("id3", 1, 0, 0, 0, 0, 6'b000111, 0, 0);
        step("id3_end", 0, 0, 0, 0, 0, 6'b000000, 0, 0);
        chk("id3_perf3", 32'(exp_perf), 32'd3);

        // Length 5 op
        step("l5_req", 0, 1, 5, 0, 0, 6'b001111, 0, 0);
        for (int i = 0; i < 4; i++)
            step("l5_run", 0, 0, 0, 0, 0, 6'b001111, 1, 0);
        step("l5_done", 0, 0, 0, 0, 0, 6'b000000, 0, 1);
        step("l5_idle", 0, 0, 0, 0, 0, 6'b000000, 0, 0);

        // Length 1 op
        step("l1_req", 0, 1, 1, 0, 0, 6'b001111, 0, 0);
        step("l1_done", 0, 0, 0, 0, 0, 6'b000000, 0, 1);
        step("l1_idle", 0, 0, 0, 0, 0, 6'b000000, 0, 0);

        // Length 0 request is ignored
        step("l0_req", 0, 1, 0, 0, 0, 6'b000000, 0, 0);
        step("l0_idle", 0, 0, 0, 0, 0, 6'b000000, 0, 0);
        step("l0_idle2", 0, 0, 0, 0, 0, 6'b000000, 0, 0);

        // Length 8 with ID stall held high
        step("l8_req", 1, 1, 8, 0, 0, 6'b001111, 0, 0);
        for (int i = 0; i < 7; i++)
            step("l8_run", 1, 0, 0, 0, 0, 6'b001111, 1, 0);
        step("l8_done", 1, 0, 0, 0, 0, 6'b000111, 0, 1);
        step("l8_idle", 0, 0, 0, 0, 0, 6'b000000, 0, 0);

        // Length 10 cancelled in 4th RUN cycle
        step("l10_req", 0, 1, 10, 0, 0, 6'b001111, 0, 0);
        for (int i = 0; i < 3; i++)
            step("l10_run", 0, 0, 0, 0, 0, 6'b001111, 1, 0);
        step("l10_cancel", 0, 0, 0, 1, 0, 6'b001111, 1, 0);
        step("l10_after", 0, 0, 0, 0, 0, 6'b000000, 0, 0);
        step("l10_after2", 0, 0, 0, 0, 0, 6'b000000, 0, 0);

        // Back-to-back ops with a one-cycle gap
        step("b2b_req", 0, 1, 2, 0, 0, 6'b001111, 0, 0);
        step("b2b_run", 0, 0, 0, 0, 0, 6'b001111, 1, 0);
        step("b2b_done", 0, 1, 3, 0, 0, 6'b000000, 0, 1);
        step("b2b_req2", 0, 1, 3, 0, 0, 6'b001111, 0, 0);
        step("b2b_run2", 0, 0, 0, 0, 0, 6'b001111, 1, 0);
        step("b2b_run2", 0, 0, 0, 0, 0, 6'b001111, 1, 0);
        step("b2b_done2", 0, 0, 0, 0, 0, 6'b000000, 0, 1);

        // Perf clear while stalling
        step("clr_stall", 1, 0, 0, 0, 1, 6'b000111, 0, 0);
        step("clr_after", 0, 0, 0, 0, 0, 6'b000000, 0, 0);

        // Asynchronous reset mid-RUN
        step("ar_req", 0, 1, 6, 0, 0, 6'b001111, 0, 0);
        step("ar_run", 0, 0, 0, 0, 0, 6'b001111, 1, 0);
        step("ar_run", 0, 0, 0, 0, 0, 6'b001111, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_stall", 32'(stall), 32'h0);
        chk("ar_busy", 32'(mc.mc_busy_o), 32'h0);
        chk("ar_done", 32'(mc.mc_done_o), 32'h0);
        chk("ar_perf", 32'(perf), 32'h0);
        exp_perf = 16'h0000;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step("ar_idle", 0, 0, 0, 0, 0, 6'b000000, 0, 0);
        step("ar_req2", 0, 1, 1, 0, 0, 6'b001111, 0, 0);
        step("ar_done2", 0, 0, 0, 0, 0, 6'b000000, 0, 1);

        // Saturation of the perf counter
        for (int i = 0; i < 65540; i++)
            step("sat", 1, 0, 0, 0, 0, 6'b000111, 0, 0);
        chk("sat_model", 32'(exp_perf), 32'hFFFF);
        chk("sat_hold", 32'(perf), 32'hFFFF);
        step("sat_clr", 1, 0, 0, 0, 1, 6'b000111, 0, 0);
        step("sat_zero", 0, 0, 0, 0, 0, 6'b000000, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline stall controller for the five-stage MIPS32 core. It merges the ID-stage load-use stall request with multi-cycle EX operations such as iterative divide and two-pass madd/msub, and drives the `stall` vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers. A small FSM and down-counter hold the pipeline frozen for the requested number of EX cycles and signal completion. A saturating counter records total frozen cycles for performance monitoring.

## Interface
- `LEN_W`, default 6: width of the multi-cycle length field; maximum op length is 2^LEN_W-1 cycles.
- `PERF_W`, default 16: width of the stall performance counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low (0 = reset asserted).
- `stallreq_id_i`  in  1  ID load-use hazard; stall pc, if_id and id_ex.
- `mc_req_i`  in  1  EX requests a multi-cycle operation, sampled in IDLE only.
- `mc_len_i`  in  LEN_W  total EX cycles of the op, including the request cycle.
- `mc_cancel_i`  in  1  flush or exception; aborts a running op.
- `perf_clr_i`  in  1  synchronous clear of the performance counter.
- `stall_o`  out  6  bit 0 = pc, 1 = if_id, 2 = id_ex, 3 = ex_mem, 4 = mem_wb, 5 = wb; 1 = Stop.
- `mc_busy_o`  out  1  registered; high in state RUN.
- `mc_done_o`  out  1  registered; single-cycle pulse in state DONE.
- `stall_cnt_o`  out  PERF_W  number of cycles with `stall_o[0]` = 1, saturating.

## Operation
- FSM states:
  - IDLE, the reset state.
  - RUN: multi-cycle op in progress.
  - DONE: one completion cycle.
- `cnt` register is LEN_W bits and resets to 0.
- IDLE:
  - If `mc_req_i` = 1 and `mc_len_i` ≥ 2: `stall_o` = 6'b001111 combinationally, `cnt` ← `mc_len_i` − 1, next state RUN.
  - If `mc_req_i` = 1 and `mc_len_i` = 1: `stall_o` = 6'b001111, next state DONE.
  - If `mc_req_i` = 1 and `mc_len_i` = 0: the request is ignored. `stall_o` is driven from `stallreq_id_i` only and the state stays IDLE.
  - If there is no valid request: `stall_o` = 6'b000111 when `stallreq_id_i` = 1, otherwise 6'b000000.
- RUN:
  - `stall_o` = 6'b001111.
  - Each cycle `cnt` ← `cnt` − 1.
  - When `cnt` = 1, next state DONE.
  - `stallreq_id_i` and `mc_req_i` are ignored.
- DONE:
  - `mc_done_o` = 1.
  - `stall_o` is driven from `stallreq_id_i` only, so EX writes its result to ex_mem this cycle.
  - `mc_req_i` is ignored. EX must deassert its request in this cycle.
  - Next state is always IDLE.
- `mc_cancel_i` = 1:
  - In RUN or IDLE: next state IDLE, `cnt` ← 0, no DONE pulse.
  - In RUN the cancel cycle still outputs 6'b001111.
  - In IDLE a simultaneous `mc_req_i` is dropped.
  - In DONE: ignored; the pulse completes.
- EX stall has priority over ID stall. The two never produce any other code. Bits 4 and 5 are always 0.
- `stall_cnt_o`:
  - +1 on each rising edge where `stall_o[0]` = 1.
  - Holds at all-ones.
  - `perf_clr_i` wins over increment and sets the count to 0.

## Timing
- An op of length L freezes stages 0–3 for exactly L cycles: the request cycle plus L−1 RUN cycles. `mc_done_o` asserts in cycle L+1 with the stall released.
- Back-to-back ops: a new request is accepted in the first IDLE cycle after DONE. There is therefore a minimum of 1 non-EX-stall cycle between ops.
- Reset (`rst` = 0, asynchronous, any state, including mid-op):
  - State IDLE, `cnt` = 0, `mc_busy_o` = 0, `mc_done_o` = 0, `stall_cnt_o` = 0.
  - `stall_o` is forced to 6'b000000 while reset is asserted.
- Release is synchronous: the first valid request is sampled on the first edge after `rst` goes high.

## Test plan
- `stallreq_id_i` = 1 for 3 cycles in IDLE → `stall_o` = 000111 for those 3 cycles; `stall_cnt_o` goes 0→3.
- `mc_req_i`, `mc_len_i` = 5 → `stall_o` = 001111 for 5 cycles and `mc_busy_o` high for 4 cycles, then `mc_done_o` = 1 for 1 cycle with `stall_o` = 000000.
- `mc_len_i` = 1 → 1 stall cycle, then DONE. `mc_len_i` = 0 → no stall, no DONE.
- `mc_len_i` = 8 with `stallreq_id_i` held high throughout:
  - `stall_o` = 001111 for 8 cycles.
  - In the DONE cycle `stall_o` = 000111.
- `mc_len_i` = 10, `mc_cancel_i` pulsed in the 4th RUN cycle:
  - IDLE on the next edge.
  - No `mc_done_o`.
  - `stall_o` = 000000 afterwards.
- Reset boundaries:
  - `rst` asserted mid-RUN → all outputs reset immediately, asynchronously.
  - `stall_cnt_o` driven to all-ones → holds at 0xFFFF.
  - `perf_clr_i` while stalling → 0 on the next edge.
